// File: rtl/llc_req_responder_if.sv
// L2 request/response channels plus the single-beat line memory port
// of the memory-side coherence responder.
interface llc_req_responder_if #(
    parameter int LINE_ADDR_BITS = 28,
    parameter int BITS_PER_LINE  = 128,
    parameter int REQ_ID_BITS    = 4
);
    logic                      llc_req_in_valid;
    logic                      llc_req_in_ready;
    logic [2:0]                llc_req_in_coh_msg;
    logic [LINE_ADDR_BITS-1:0] llc_req_in_addr;
    logic [BITS_PER_LINE-1:0]  llc_req_in_line;
    logic [REQ_ID_BITS-1:0]    llc_req_in_id;

    logic                      llc_rsp_out_valid;
    logic                      llc_rsp_out_ready;
    logic [1:0]                llc_rsp_out_coh_msg;
    logic [LINE_ADDR_BITS-1:0] llc_rsp_out_addr;
    logic [BITS_PER_LINE-1:0]  llc_rsp_out_line;
    logic [3:0]                llc_rsp_out_invack_cnt;
    logic [REQ_ID_BITS-1:0]    llc_rsp_out_dest_id;

    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic                      mem_req_hwrite;
    logic [LINE_ADDR_BITS-1:0] mem_req_addr;
    logic [BITS_PER_LINE-1:0]  mem_req_line;

    logic                      mem_rsp_valid;
    logic                      mem_rsp_ready;
    logic [BITS_PER_LINE-1:0]  mem_rsp_line;

    modport slave (
        input  llc_req_in_valid, llc_req_in_coh_msg, llc_req_in_addr,
        input  llc_req_in_line, llc_req_in_id,
        output llc_req_in_ready,
        output llc_rsp_out_valid, llc_rsp_out_coh_msg, llc_rsp_out_addr,
        output llc_rsp_out_line, llc_rsp_out_invack_cnt, llc_rsp_out_dest_id,
        input  llc_rsp_out_ready,
        output mem_req_valid, mem_req_hwrite, mem_req_addr, mem_req_line,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_line,
        output mem_rsp_ready
    );

    modport master (
        output llc_req_in_valid, llc_req_in_coh_msg, llc_req_in_addr,
        output llc_req_in_line, llc_req_in_id,
        input  llc_req_in_ready,
        input  llc_rsp_out_valid, llc_rsp_out_coh_msg, llc_rsp_out_addr,
        input  llc_rsp_out_line, llc_rsp_out_invack_cnt, llc_rsp_out_dest_id,
        output llc_rsp_out_ready,
        input  mem_req_valid, mem_req_hwrite, mem_req_addr, mem_req_line,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_line,
        input  mem_rsp_ready
    );
endinterface

// File: rtl/llc_req_responder.sv
// Memory-side far end of the L2 coherence protocol: one transaction in
// flight, no sharer tracking, single-beat line memory port.
module llc_req_responder #(
    parameter int LINE_ADDR_BITS = 28,
    parameter int BITS_PER_LINE  = 128,
    parameter int REQ_ID_BITS    = 4,
    parameter int CNT_BITS       = 16
) (
    input  logic                clk,
    input  logic                rst,
    llc_req_responder_if.slave  bus,
    output logic                bad_msg,
    output logic [CNT_BITS-1:0] served_cnt
);
    localparam logic [2:0] REQ_GETS = 3'b000;
    localparam logic [2:0] REQ_GETM = 3'b001;
    localparam logic [2:0] REQ_PUTS = 3'b010;
    localparam logic [2:0] REQ_PUTM = 3'b011;

    localparam logic [1:0] RSP_DATA   = 2'b00;
    localparam logic [1:0] RSP_EDATA  = 2'b01;
    localparam logic [1:0] RSP_PUTACK = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        MEM_RD_REQ,
        MEM_RD_WAIT,
        MEM_WR_REQ,
        SEND_RSP
    } state_t;

    state_t state;
    state_t state_next;

    logic [LINE_ADDR_BITS-1:0] addr_q;
    logic [REQ_ID_BITS-1:0]    id_q;
    logic [BITS_PER_LINE-1:0]  wr_line_q;
    logic [BITS_PER_LINE-1:0]  rd_line_q;
    logic [1:0]                rsp_msg_q;

    logic req_ready;
    logic rsp_valid;
    logic mreq_valid;
    logic mreq_write;
    logic mrsp_ready;

    logic req_fire;
    logic mrsp_fire;
    logic rsp_fire;

    assign req_fire  = req_ready & bus.llc_req_in_valid;
    assign mrsp_fire = mrsp_ready & bus.mem_rsp_valid;
    assign rsp_fire  = rsp_valid & bus.llc_rsp_out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake outputs decode the state register only, never an input.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        mreq_valid = 1'b0;
        mreq_write = 1'b0;
        mrsp_ready = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.llc_req_in_valid) begin
                    unique case (bus.llc_req_in_coh_msg)
                        REQ_GETS, REQ_GETM: state_next = MEM_RD_REQ;
                        REQ_PUTM:           state_next = MEM_WR_REQ;
                        REQ_PUTS:           state_next = SEND_RSP;
                        default:            state_next = IDLE;
                    endcase
                end
            end
            MEM_RD_REQ: begin
                mreq_valid = 1'b1;
                if (bus.mem_req_ready) state_next = MEM_RD_WAIT;
            end
            MEM_RD_WAIT: begin
                mrsp_ready = 1'b1;
                if (bus.mem_rsp_valid) state_next = SEND_RSP;
            end
            MEM_WR_REQ: begin
                mreq_valid = 1'b1;
                mreq_write = 1'b1;
                if (bus.mem_req_ready) state_next = SEND_RSP;
            end
            SEND_RSP: begin
                rsp_valid = 1'b1;
                if (bus.llc_rsp_out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // With no sharers anywhere, a GetS can always be granted exclusive.
    function automatic logic [1:0] rsp_for(input logic [2:0] msg);
        logic [1:0] r;
        r = RSP_PUTACK;
        unique case (msg)
            REQ_GETS: r = RSP_EDATA;
            REQ_GETM: r = RSP_DATA;
            default:  r = RSP_PUTACK;
        endcase
        return r;
    endfunction

    function automatic logic is_bad(input logic [2:0] msg);
        logic b;
        b = 1'b1;
        unique case (msg)
            REQ_GETS, REQ_GETM, REQ_PUTS, REQ_PUTM: b = 1'b0;
            default:                                b = 1'b1;
        endcase
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            id_q       <= '0;
            wr_line_q  <= '0;
            rd_line_q  <= '0;
            rsp_msg_q  <= '0;
            bad_msg    <= 1'b0;
            served_cnt <= '0;
        end else begin
            bad_msg <= 1'b0;
            if (req_fire) begin
                addr_q    <= bus.llc_req_in_addr;
                id_q      <= bus.llc_req_in_id;
                wr_line_q <= bus.llc_req_in_line;
                rd_line_q <= '0;
                rsp_msg_q <= rsp_for(bus.llc_req_in_coh_msg);
                bad_msg   <= is_bad(bus.llc_req_in_coh_msg);
            end
            if (mrsp_fire) begin
                rd_line_q <= bus.mem_rsp_line;
            end
            if (rsp_fire) begin
                served_cnt <= served_cnt + CNT_BITS'(1);
            end
        end
    end

    assign bus.llc_req_in_ready       = req_ready;
    assign bus.llc_rsp_out_valid      = rsp_valid;
    assign bus.llc_rsp_out_coh_msg    = rsp_msg_q;
    assign bus.llc_rsp_out_addr       = addr_q;
    assign bus.llc_rsp_out_line       = rd_line_q;
    assign bus.llc_rsp_out_invack_cnt = 4'd0;
    assign bus.llc_rsp_out_dest_id    = id_q;
    assign bus.mem_req_valid          = mreq_valid;
    assign bus.mem_req_hwrite         = mreq_write;
    assign bus.mem_req_addr           = addr_q;
    assign bus.mem_req_line           = wr_line_q;
    assign bus.mem_rsp_ready          = mrsp_ready;
endmodule

// File: tb/tb_llc_req_responder.sv
// Self-checking bench for llc_req_responder: vector table, hand-written
// corner sequences and randomized traffic against a transaction model.
`timescale 1ns/1ps
module tb_llc_req_responder;
    localparam int LAB = 28;
    localparam int BPL = 128;
    localparam int RIB = 4;
    localparam int CB  = 8;

    localparam logic [2:0] GETS = 3'b000;
    localparam logic [2:0] GETM = 3'b001;
    localparam logic [2:0] PUTS = 3'b010;
    localparam logic [2:0] PUTM = 3'b011;
    localparam logic [1:0] DATA   = 2'b00;
    localparam logic [1:0] EDATA  = 2'b01;
    localparam logic [1:0] PUTACK = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          bad_msg;
    logic [CB-1:0] served_cnt;

    llc_req_responder_if #(
        .LINE_ADDR_BITS(LAB), .BITS_PER_LINE(BPL), .REQ_ID_BITS(RIB)
    ) bus ();

    llc_req_responder #(
        .LINE_ADDR_BITS(LAB), .BITS_PER_LINE(BPL),
        .REQ_ID_BITS(RIB), .CNT_BITS(CB)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .bad_msg(bad_msg), .served_cnt(served_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc_no = 0;

    int mem_wait    = 0;
    int mem_rdy_pct = 100;
    int rsp_rdy_pct = 100;

    logic [BPL-1:0] mem [logic [LAB-1:0]];
    bit             rd_busy;
    int             rd_cnt;
    logic [LAB-1:0] rd_addr;

    typedef struct {
        logic [1:0]     msg;
        logic [LAB-1:0] addr;
        logic [RIB-1:0] id;
        logic [BPL-1:0] line;
    } rsp_t;

    rsp_t           pend;
    bit             busy, want_mreq, want_mrsp, want_rsp, exp_wr, exp_bad;
    logic [LAB-1:0] exp_maddr;
    logic [BPL-1:0] exp_mline;
    logic [CB-1:0]  exp_cnt;
    int             acc_cyc, last_lat, n_acc, n_rsp;
    bit             lat_armed;
    logic [1:0]     last_msg;

    function automatic logic [BPL-1:0] mem_rd(input logic [LAB-1:0] a);
        if (mem.exists(a)) return mem[a];
        return {4{4'h5, a}};
    endfunction

    task automatic chk(input string name, input logic [BPL-1:0] act,
                       input logic [BPL-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    task automatic clear_model();
        busy = 0; want_mreq = 0; want_mrsp = 0; want_rsp = 0;
        exp_wr = 0; exp_bad = 0; exp_cnt = '0;
        rd_busy = 0; lat_armed = 0;
    endtask

    // One clock: check outputs, drive memory/consumer, advance the model.
    task automatic cyc();
        bit rf, mqf, mrf, of;
        chk("req_ready", bus.llc_req_in_ready, !busy);
        chk("mem_req_valid", bus.mem_req_valid, want_mreq);
        chk("mem_rsp_ready", bus.mem_rsp_ready, want_mrsp);
        chk("rsp_valid", bus.llc_rsp_out_valid, want_rsp);
        chk("bad_msg", bad_msg, exp_bad);
        chk("served_cnt", served_cnt, exp_cnt);
        if (want_mreq && bus.mem_req_valid) begin
            chk("mem_hwrite", bus.mem_req_hwrite, exp_wr);
            chk("mem_addr", bus.mem_req_addr, exp_maddr);
            if (exp_wr) chk("mem_wdata", bus.mem_req_line, exp_mline);
        end
        if (want_rsp && bus.llc_rsp_out_valid) begin
            chk("rsp_msg", bus.llc_rsp_out_coh_msg, pend.msg);
            chk("rsp_addr", bus.llc_rsp_out_addr, pend.addr);
            chk("rsp_line", bus.llc_rsp_out_line, pend.line);
            chk("rsp_dest", bus.llc_rsp_out_dest_id, pend.id);
            chk("rsp_invack", bus.llc_rsp_out_invack_cnt, 0);
        end
        if (lat_armed && bus.llc_rsp_out_valid) begin
            last_lat  = cyc_no - acc_cyc;
            lat_armed = 0;
        end

        bus.mem_req_ready = ($urandom_range(99) < mem_rdy_pct);
        if (rd_busy && rd_cnt == 0) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_line  = mem_rd(rd_addr);
        end else begin
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_line  = {$urandom, $urandom, $urandom, $urandom};
        end
        if (rd_busy && rd_cnt > 0) rd_cnt--;
        bus.llc_rsp_out_ready = ($urandom_range(99) < rsp_rdy_pct);

        rf  = bus.llc_req_in_valid && bus.llc_req_in_ready;
        mqf = bus.mem_req_valid && bus.mem_req_ready;
        mrf = bus.mem_rsp_valid && bus.mem_rsp_ready;
        of  = bus.llc_rsp_out_valid && bus.llc_rsp_out_ready;
        exp_bad = 0;

        if (rst) begin
            clear_model();
        end else begin
            if (mqf) begin
                if (bus.mem_req_hwrite) begin
                    mem[bus.mem_req_addr] = bus.mem_req_line;
                end else begin
                    rd_busy = 1; rd_cnt = 1 + mem_wait;
                    rd_addr = bus.mem_req_addr;
                end
                want_mreq = 0;
                if (exp_wr) want_rsp = 1;
                else want_mrsp = 1;
            end
            if (mrf) begin
                rd_busy = 0; want_mrsp = 0; want_rsp = 1;
            end
            if (of) begin
                want_rsp = 0; busy = 0; exp_cnt++; n_rsp++;
                last_msg = bus.llc_rsp_out_coh_msg;
            end
            if (rf) begin
                n_acc++;
                pend.addr = bus.llc_req_in_addr;
                pend.id   = bus.llc_req_in_id;
                pend.line = '0;
                pend.msg  = PUTACK;
                exp_maddr = bus.llc_req_in_addr;
                exp_mline = bus.llc_req_in_line;
                acc_cyc = cyc_no; lat_armed = 1; busy = 1;
                case (bus.llc_req_in_coh_msg)
                    GETS: begin
                        pend.msg = EDATA; pend.line = mem_rd(pend.addr);
                        want_mreq = 1; exp_wr = 0;
                    end
                    GETM: begin
                        pend.msg = DATA; pend.line = mem_rd(pend.addr);
                        want_mreq = 1; exp_wr = 0;
                    end
                    PUTS: want_rsp = 1;
                    PUTM: begin want_mreq = 1; exp_wr = 1; end
                    default: begin
                        busy = 0; exp_bad = 1; lat_armed = 0; last_lat = 0;
                    end
                endcase
            end
        end
        @(negedge clk);
        cyc_no++;
    endtask

    task automatic send(input logic [2:0] m, input logic [LAB-1:0] a,
                        input logic [RIB-1:0] id, input logic [BPL-1:0] ln);
        bit done = 0;
        bus.llc_req_in_valid   = 1'b1;
        bus.llc_req_in_coh_msg = m;
        bus.llc_req_in_addr    = a;
        bus.llc_req_in_id      = id;
        bus.llc_req_in_line    = ln;
        last_lat = -1;
        for (int i = 0; i < 200 && !done; i++) begin
            done = bus.llc_req_in_ready;
            cyc();
        end
        bus.llc_req_in_valid = 1'b0;
        chki("req_accept_timeout", int'(done), 1);
    endtask

    task automatic wait_idle();
        int i = 0;
        do begin cyc(); i++; end while (busy && i < 300);
        chki("idle_timeout", int'(busy), 0);
        cyc();
    endtask

    typedef struct {
        logic [2:0]     msg;
        logic [LAB-1:0] addr;
        logic [RIB-1:0] id;
        logic [BPL-1:0] line;
        int             wt;
        logic [1:0]     rsp;
        int             lat;
    } vec_t;

    vec_t vt[6];

    initial begin
        int a0, nr0;
        bit seen;
        rst = 1'b1;
        bus.llc_req_in_valid = 0; bus.llc_req_in_coh_msg = 0;
        bus.llc_req_in_addr = 0; bus.llc_req_in_id = 0; bus.llc_req_in_line = 0;
        bus.llc_rsp_out_ready = 0; bus.mem_req_ready = 0;
        bus.mem_rsp_valid = 0; bus.mem_rsp_line = 0;
        clear_model();
        n_acc = 0; n_rsp = 0; last_lat = -1; last_msg = '0;
        mem[28'h0000123] = {16{8'hA5}};

        vt[0] = '{GETS, 28'h0000123, 4'd2, '0, 3, EDATA, 7};
        vt[1] = '{GETM, 28'h0FFFFFF, 4'd5, '0, 0, DATA, 4};
        vt[2] = '{PUTM, 28'h0000040, 4'd1, {4{32'hDEADBEEF}}, 0, PUTACK, 2};
        vt[3] = '{PUTS, 28'h0000040, 4'd3, '0, 0, PUTACK, 1};
        vt[4] = '{3'b111, 28'h0000077, 4'd7, '0, 0, PUTACK, 0};
        vt[5] = '{GETS, 28'h0000040, 4'd9, '0, 0, EDATA, 4};

        repeat (2) @(negedge clk);
        cyc();
        chk("rst_req_ready", bus.llc_req_in_ready, 1);
        chk("rst_rsp_valid", bus.llc_rsp_out_valid, 0);
        chk("rst_mem_req_valid", bus.mem_req_valid, 0);
        chk("rst_mem_rsp_ready", bus.mem_rsp_ready, 0);
        chk("rst_rsp_line", bus.llc_rsp_out_line, 0);
        chk("rst_rsp_addr", bus.llc_rsp_out_addr, 0);
        chk("rst_mem_line", bus.mem_req_line, 0);
        chk("rst_served", served_cnt, 0);
        chk("rst_bad_msg", bad_msg, 0);
        rst = 1'b0;
        cyc();

        foreach (vt[i]) begin
            mem_wait = vt[i].wt;
            nr0 = n_rsp;
            send(vt[i].msg, vt[i].addr, vt[i].id, vt[i].line);
            wait_idle();
            chki("vec_latency", last_lat, vt[i].lat);
            if (vt[i].lat != 0) chk("vec_rsp_msg", last_msg, vt[i].rsp);
            else chki("vec_no_rsp", n_rsp - nr0, 0);
            if (i == 0) chk("vec_served_first", served_cnt, 1);
        end
        chk("putm_mem_content", mem_rd(28'h0000040), {4{32'hDEADBEEF}});

        // Response backpressure with a second request waiting.
        mem_wait = 0; rsp_rdy_pct = 0;
        send(GETS, 28'h0000200, 4'd4, '0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            seen = bus.llc_rsp_out_valid;
            if (!seen) cyc();
        end
        chki("bp_rsp_seen", int'(seen), 1);
        a0 = n_acc;
        bus.llc_req_in_valid = 1'b1; bus.llc_req_in_coh_msg = PUTS;
        bus.llc_req_in_addr = 28'h0000210; bus.llc_req_in_id = 4'd6;
        repeat (10) cyc();
        chki("bp_no_accept", n_acc - a0, 0);
        rsp_rdy_pct = 100;
        cyc();
        chk("bp_ready_after_rsp", bus.llc_req_in_ready, 1);
        cyc();
        bus.llc_req_in_valid = 1'b0;
        chki("bp_second_accept", n_acc - a0, 1);
        wait_idle();

        // Reset while waiting on memory read data.
        mem_wait = 5;
        send(GETM, 28'h0000300, 4'd8, '0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            seen = bus.mem_rsp_ready;
            if (!seen) cyc();
        end
        chki("rst_mid_reached_wait", int'(seen), 1);
        rst = 1'b1;
        cyc();
        chk("mid_rst_req_ready", bus.llc_req_in_ready, 1);
        chk("mid_rst_rsp_valid", bus.llc_rsp_out_valid, 0);
        chk("mid_rst_mem_req_valid", bus.mem_req_valid, 0);
        chk("mid_rst_mem_rsp_ready", bus.mem_rsp_ready, 0);
        chk("mid_rst_served", served_cnt, 0);
        rst = 1'b0;
        cyc();
        mem_wait = 0;
        send(GETS, 28'h0000123, 4'd2, '0);
        wait_idle();
        chk("post_rst_served", served_cnt, 1);

        // Counter wrap at 2^CB-1.
        for (int i = 1; i < 255; i++) begin
            send(PUTS, LAB'(i), RIB'(i), '0);
            wait_idle();
        end
        chk("wrap_pre", served_cnt, 255);
        send(PUTS, 28'h0000ABC, 4'd1, '0);
        wait_idle();
        chk("wrap_zero", served_cnt, 0);

        // Randomized traffic with memory and consumer backpressure.
        mem_rdy_pct = 70; rsp_rdy_pct = 60;
        for (int n = 0; n < 200; n++) begin
            logic [2:0] m;
            mem_wait = $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0) m = 3'($urandom_range(4, 7));
            else m = 3'($urandom_range(0, 3));
            send(m, LAB'($urandom_range(0, 7) * 16), RIB'($urandom),
                 {$urandom, $urandom, $urandom, $urandom});
            repeat ($urandom_range(0, 2)) cyc();
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
